// File: rtl/mul_pkg.sv
// Shared types, constants and Booth step for the pairwise multiply DMA engine.
// Build option FAST_MUL_EN (see mul_dma_engine) does not change anything here.
package mul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    STORE,
    NEXT,
    DONE
  } state_t;

  localparam int OP_BYTES   = 2;
  localparam int PROD_BYTES = 4;
  localparam int MUL_CYCLES = 16;

  typedef logic signed [15:0] operand_t;
  typedef logic signed [31:0] product_t;

  typedef struct packed {
    logic signed [16:0] acc;
    logic [15:0]        q;
    logic               q1;
  } booth_t;

  // One radix-2 Booth iteration: add/sub, then arithmetic shift of {acc,q,q1}.
  function automatic booth_t booth_step(
    input booth_t   s,
    input operand_t m
  );
    logic signed [16:0] mx;
    logic signed [16:0] sum;
    booth_t             r;
    mx = {m[15], m};
    unique case ({s.q[0], s.q1})
      2'b01:   sum = s.acc + mx;
      2'b10:   sum = s.acc - mx;
      default: sum = s.acc;
    endcase
    r.acc = {sum[16], sum[16:1]};
    r.q   = {sum[0], s.q[15:1]};
    r.q1  = s.q[0];
    return r;
  endfunction

endpackage

// File: rtl/mul_dma_engine_if.sv
// Start/done handshake plus byte-wide data memory port of the engine.
// master: engine side, slave: top-level / memory side.
interface mul_dma_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;

  modport master (
    input  start,
    input  mem_rd_data,
    output done,
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data
  );

  modport slave (
    output start,
    output mem_rd_data,
    input  done,
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data
  );
endinterface

// File: rtl/mul_dma_engine_booth.sv
// 16x16 signed sequential radix-2 Booth multiplier, 16 cycles per product.
// The first iteration is folded into the load cycle.
module booth_mul16
  import mul_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  operand_t a,
  input  operand_t b,
  output logic     busy,
  output logic     valid,
  output product_t p
);

  booth_t     st;
  booth_t     seed;
  operand_t   m;
  logic [3:0] cnt;

  assign seed = '{acc: '0, q: b, q1: 1'b0};
  assign p    = {st.acc[15:0], st.q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= '0;
      m     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      st    <= booth_step(seed, a);
      m     <= a;
      cnt   <= 4'd1;
      busy  <= 1'b1;
      valid <= 1'b0;
    end else if (busy) begin
      st  <= booth_step(st, m);
      cnt <= cnt + 4'd1;
      if (cnt == 4'(MUL_CYCLES - 1)) begin
        busy  <= 1'b0;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_dma_engine.sv
// Reads 16 signed 16-bit operand pairs, writes 32-bit products big-endian.
// Define FAST_MUL_EN for a single-cycle combinational multiply.
module mul_dma_engine
  import mul_pkg::*;
#(
  parameter int NUM_PAIRS = 16,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 64,
  parameter int ADDR_W    = 8
) (
  input logic       clk,
  input logic       rst_n,
  mul_dma_if.master bus
);

  localparam int IDX_W =
    (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int SRC_STRIDE = 2 * OP_BYTES;

  state_t            state;
  state_t            state_n;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  idx;
  logic              start_q;
  logic [31:0]       sr;
  operand_t          op_lo;
  operand_t          op_hi;
  product_t          prod;
  logic              mul_last;
  logic              wr_ok;
  logic              last_pair;
  logic [1:0]        ld_off;
  logic [ADDR_W-1:0] src_a;
  logic [ADDR_W-1:0] dst_a;

  assign op_lo = sr[31:16];
  assign op_hi = sr[15:0];

  assign last_pair = idx == IDX_W'(NUM_PAIRS - 1);
  assign ld_off    = (cnt > 4'd3) ? 2'd3 : cnt[1:0];

  assign src_a = ADDR_W'(SRC_BASE)
               + ADDR_W'(idx) * ADDR_W'(SRC_STRIDE);
  assign dst_a = ADDR_W'(DST_BASE)
               + ADDR_W'(idx) * ADDR_W'(PROD_BYTES);

`ifdef FAST_MUL_EN
  product_t prod_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_r <= '0;
    end else if (state == MUL) begin
      prod_r <= product_t'(op_hi) * product_t'(op_lo);
    end
  end

  assign prod     = prod_r;
  assign mul_last = 1'b1;
  assign wr_ok    = 1'b1;
`else
  logic mul_busy;
  logic mul_valid;

  booth_mul16 u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == MUL && cnt == 4'd0),
    .a     (op_hi),
    .b     (op_lo),
    .busy  (mul_busy),
    .valid (mul_valid),
    .p     (prod)
  );

  assign mul_last = mul_busy
                 && cnt == 4'(MUL_CYCLES - 1);
  assign wr_ok    = mul_valid;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // NEXT is resolved in the last STORE beat so a pair stays at 25 cycles.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (start_q && !bus.start) state_n = LOAD;
      LOAD:
        if (cnt == 4'(SRC_STRIDE)) state_n = MUL;
      MUL:
        if (mul_last) state_n = STORE;
      STORE:
        if (cnt == 4'(PROD_BYTES - 1))
          state_n = last_pair ? DONE : LOAD;
      DONE:
        if (bus.start) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
      sr      <= '0;
    end else begin
      start_q <= bus.start;
      if (state_n != state) begin
        cnt <= '0;
      end else if (state != IDLE && state != DONE) begin
        cnt <= cnt + 4'd1;
      end
      if (state == LOAD && cnt != 4'd0) begin
        sr <= {sr[23:0], bus.mem_rd_data};
      end
      if (state == STORE && cnt == 4'(PROD_BYTES - 1)) begin
        idx <= last_pair ? '0 : idx + 1'b1;
      end
    end
  end

  always_comb begin
    bus.done        = 1'b0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    unique case (state)
      LOAD: begin
        bus.mem_addr = src_a + ADDR_W'(ld_off);
      end
      STORE: begin
        bus.mem_addr    = dst_a + ADDR_W'(cnt[1:0]);
        bus.mem_wr_en   = wr_ok;
        bus.mem_wr_data = 8'(prod >> {~cnt[1:0], 3'b000});
      end
      DONE: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mul_dma_engine.sv
// Directed bench for mul_dma_engine with a byte memory model.
// Run length follows FAST_MUL_EN when that macro is defined.
module tb_mul_dma_engine;
  import mul_pkg::*;

`ifdef FAST_MUL_EN
  localparam int RUN = 160;
`else
  localparam int RUN = 400;
`endif
  localparam int PAIR_CYC = RUN / 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pre;
  int         n_tests = 0;
  int         n_fail = 0;
  int         wr_cnt = 0;
  int         wr_bad = 0;
  int         rd_bad = 0;
  logic [7:0] mem [0:255];
  logic [7:0] img [0:127];

  mul_dma_if #(.ADDR_W(8)) bus ();

  mul_dma_engine #(
    .NUM_PAIRS (16),
    .SRC_BASE  (0),
    .DST_BASE  (64),
    .ADDR_W    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 128; i++) mem[i] <= img[i];
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_addr] <= bus.mem_wr_data;
    end
    bus.mem_rd_data <= mem[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      wr_cnt++;
      if (bus.mem_addr < 8'd64 || bus.mem_addr > 8'd127) wr_bad++;
    end
    if (dut.state == LOAD && bus.mem_addr >= 8'd64) rd_bad++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] prod_at(input int k);
    return {mem[64+4*k], mem[65+4*k], mem[66+4*k], mem[67+4*k]};
  endfunction

  function automatic logic [31:0] model(input int k);
    logic signed [15:0] a0;
    logic signed [15:0] a1;
    a0 = {img[4*k], img[4*k+1]};
    a1 = {img[4*k+2], img[4*k+3]};
    return 32'(int'(a1) * int'(a0));
  endfunction

  task automatic preload();
    for (int i = 64; i < 128; i++) img[i] = 8'hAA;
    pre = 1'b1;
    tick();
    pre = 1'b0;
  endtask

  task automatic run(input string tag, input int glitch);
    int lat;
    wr_cnt = 0;
    wr_bad = 0;
    rd_bad = 0;
    bus.start = 1'b1;
    tick();
    chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= RUN + 20 && lat == 0; i++) begin
      if (glitch > 0 && i == glitch) bus.start = 1'b1;
      if (glitch > 0 && i == glitch + 1) bus.start = 1'b0;
      tick();
      if (bus.done === 1'b1) lat = i;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(RUN + 1));
    chk({tag, "_strobes"}, 32'(wr_cnt), 32'd64);
    chk({tag, "_wr_range"}, 32'(wr_bad), 32'd0);
    chk({tag, "_rd_range"}, 32'(rd_bad), 32'd0);
  endtask

  task automatic check_pairs(input string tag);
    int bad;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_p%0d", tag, k), prod_at(k), model(k));
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== img[i]) bad++;
    chk({tag, "_src_intact"}, 32'(bad), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    pre       = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 128; i++) img[i] = 8'h00;
    repeat (3) tick();
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.mem_wr_data), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_no_launch", 32'(dut.state), 32'(IDLE));

    img[1] = 8'h03;
    img[2] = 8'hFF;
    img[3] = 8'hF9;
    preload();
    run("basic", 0);
    chk("basic_p0_hand", prod_at(0), 32'hFFFF_FFEB);
    chk("basic_p1_hand", prod_at(1), 32'h0000_0000);
    check_pairs("basic");

    for (int i = 0; i < 64; i++) img[i] = 8'h00;
    img[0]  = 8'h80; img[2]  = 8'h80;
    img[4]  = 8'h7F; img[5]  = 8'hFF; img[6] = 8'h80;
    img[8]  = 8'hFF; img[9]  = 8'hFF;
    img[10] = 8'hFF; img[11] = 8'hFF;
    img[14] = 8'h80;
    preload();
    run("ext", 0);
    chk("ext_min_min", prod_at(0), 32'h4000_0000);
    chk("ext_max_min", prod_at(1), 32'hC000_8000);
    chk("ext_m1_m1", prod_at(2), 32'h0000_0001);
    chk("ext_zero_min", prod_at(3), 32'h0000_0000);
    check_pairs("ext");

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
      preload();
      run($sformatf("rand%0d", r), 0);
      check_pairs($sformatf("rand%0d", r));
    end

    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    preload();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5 * PAIR_CYC + 6) tick();
    chk("mid_in_mul", 32'(dut.state), 32'(MUL));
    rst_n = 1'b0;
    tick();
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    tick();
    chk("mid_keep_p4", prod_at(4), model(4));
    chk("mid_p6_unwritten", prod_at(6), 32'hAAAA_AAAA);
    run("after_rst", 0);
    check_pairs("after_rst");

    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    preload();
    run("glitch", 2 * PAIR_CYC + 3);
    check_pairs("glitch");
    repeat (3) tick();
    chk("glitch_done_hold", 32'(bus.done), 32'd1);
    chk("glitch_no_relaunch", 32'(wr_cnt), 32'd64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
